vram_arbiter: RTL

Shares the single-port synchronous video RAM between the text-mode pixel generator and the CPU bus. Each pixel period is four `pixel_state` slots. Slots TEXT_FETCH and GLYPH_FETCH belong to the pixel generator. Slots WAIT and DRAW are granted to the CPU through a req/ack handshake. The block also holds glyph data steady for the DRAW slot.

---
 rtl/vram_arbiter.sv | 87 ++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// Video RAM arbiter: pixel generator owns TEXT_FETCH/GLYPH_FETCH slots, CPU gets the rest
// through a req/ack handshake; the glyph word is held steady for the DRAW slot.
module vram_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            pixel_state,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  output logic [DATA_WIDTH-1:0] vga_data,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_vga_prev;
  logic                  r_cpu_rd_prev;
  logic [DATA_WIDTH-1:0] r_vga_hold;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;
  logic                  w_vga_slot;
  logic                  w_issue;

  assign w_vga_slot = enable && !pixel_state[1];
  // Gating with reset keeps the RAM strobe quiet while a held request waits out reset.
  assign w_issue    = !reset && !w_vga_slot && (r_state == S_IDLE) && cpu_req;

  always_comb begin
    w_state_nxt = r_state;
    mem_addr    = vga_addr;
    mem_we      = 1'b0;
    mem_wdata   = cpu_wdata;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          mem_addr    = cpu_addr;
          mem_we      = cpu_we;
          w_state_nxt = S_PEND;
        end
      end
      S_PEND:  w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_vga_prev    <= 1'b0;
      r_cpu_rd_prev <= 1'b0;
      r_vga_hold    <= '0;
      r_cpu_rdata   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_vga_prev    <= w_vga_slot;
      r_cpu_rd_prev <= w_issue && !cpu_we;
      if (r_vga_prev) begin
        r_vga_hold <= mem_rdata;
      end
      if ((r_state == S_PEND) && r_cpu_rd_prev) begin
        r_cpu_rdata <= mem_rdata;
      end
    end
  end

  assign vga_data  = r_vga_prev ? mem_rdata : r_vga_hold;
  assign cpu_rdata = r_cpu_rdata;
  assign cpu_ack   = (r_state == S_ACK);

endmodule
